// File: rtl/lms_echo_canceller_tdm.sv
// rtl/lms_echo_canceller_tdm.sv - time-multiplexed LMS echo canceller with one shared MAC
module lms_echo_canceller_tdm #(
    parameter int DW       = 16,
    parameter int CW       = 16,
    parameter int TAPS     = 32,
    parameter int MU_SHIFT = 7,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] far_data,
    input  logic [DW-1:0] near_data,
    input  logic          adapt_en,
    input  logic          bypass,
    input  logic          coef_clr,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic [CW-1:0] coef_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] est_data
);

    localparam int IW  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int ACW = DW + CW + $clog2(TAPS);
    // Working width for all saturating math; wide enough that no intermediate wraps.
    localparam int XW  = ACW + 2*DW + MU_SHIFT + 2;
    localparam logic [AW:0] TAPS_A = (AW+1)'(TAPS);

    typedef enum logic [1:0] {IDLE, FILT, ERR, UPD} state_t;

    state_t                state;
    logic signed [CW-1:0]  h [TAPS];
    logic signed [DW-1:0]  x [TAPS];
    logic signed [DW-1:0]  d;
    logic signed [DW-1:0]  e_r;
    logic signed [ACW-1:0] acc;
    logic [IW-1:0]         idx;
    logic                  byp_r;
    logic                  clr_seen;

    logic                  idx_last;
    logic                  addr_ok;
    logic signed [DW-1:0]  y_val;
    logic signed [DW-1:0]  e_val;
    logic signed [XW-1:0]  upd_sum;
    logic signed [CW-1:0]  h_new;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [XW-1:0] v);
        if ((&v[XW-1:DW-1]) || !(|v[XW-1:DW-1]))
            return v[DW-1:0];
        return v[XW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

    function automatic logic signed [CW-1:0] sat_cw(input logic signed [XW-1:0] v);
        if ((&v[XW-1:CW-1]) || !(|v[XW-1:CW-1]))
            return v[CW-1:0];
        return v[XW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    endfunction

    assign in_ready = (state == IDLE);
    assign idx_last = (idx == IW'(TAPS-1));
    assign addr_ok  = ({1'b0, coef_addr} < TAPS_A);

    assign y_val   = byp_r ? '0 : sat_dw(XW'(acc) >>> (CW-1));
    assign e_val   = sat_dw(XW'(d) - XW'(y_val));
    // Round-half-up LMS step: delta = (e*x + half) >>> (DW-1+MU_SHIFT)
    assign upd_sum = XW'(h[idx])
                   + ((XW'(e_r) * XW'(x[idx]) + (XW'(1) <<< (DW-2+MU_SHIFT))) >>> (DW-1+MU_SHIFT));
    assign h_new   = sat_cw(upd_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            d          <= '0;
            e_r        <= '0;
            byp_r      <= 1'b0;
            clr_seen   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            est_data   <= '0;
            coef_rdata <= '0;
            for (int k = 0; k < TAPS; k++) begin
                h[k] <= '0;
                x[k] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            coef_rdata <= addr_ok ? h[coef_addr[IW-1:0]] : '0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = TAPS-1; k > 0; k--)
                            x[k] <= x[k-1];
                        x[0]     <= far_data;
                        d        <= near_data;
                        byp_r    <= bypass;
                        clr_seen <= 1'b0;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= bypass ? ERR : FILT;
                    end
                end
                FILT: begin
                    acc <= acc + ACW'(h[idx]) * ACW'(x[idx]);
                    idx <= idx + 1'b1;
                    if (idx_last)
                        state <= ERR;
                end
                ERR: begin
                    out_valid <= 1'b1;
                    out_data  <= e_val;
                    est_data  <= y_val;
                    e_r       <= e_val;
                    idx       <= '0;
                    state     <= (adapt_en && !byp_r && !clr_seen && !coef_clr) ? UPD : IDLE;
                end
                UPD: begin
                    h[idx] <= h_new;
                    idx    <= idx + 1'b1;
                    if (idx_last)
                        state <= IDLE;
                end
            endcase

            // A clear wins over everything and cancels any remaining update pass.
            if (coef_clr) begin
                for (int k = 0; k < TAPS; k++) begin
                    h[k] <= '0;
                    x[k] <= '0;
                end
                clr_seen <= 1'b1;
                if (state == UPD)
                    state <= IDLE;
            end else if (coef_we && state == IDLE && addr_ok) begin
                h[coef_addr[IW-1:0]] <= coef_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lms_echo_canceller_tdm.sv
// tb/tb_lms_echo_canceller_tdm.sv - randomized bench for lms_echo_canceller_tdm against a frame-level model
module tb_lms_echo_canceller_tdm;

    localparam int DW = 16, CW = 16, TAPS = 4, MU_SHIFT = 0, AW = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, adapt_en, bypass, coef_clr, coef_we, out_valid;
    logic [DW-1:0] far_data, near_data, out_data, est_data;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_wdata, coef_rdata;

    int     checks = 0, errors = 0;
    longint hm [TAPS];
    longint xm [TAPS];

    always #5 clk = ~clk;

    lms_echo_canceller_tdm #(.DW(DW), .CW(CW), .TAPS(TAPS), .MU_SHIFT(MU_SHIFT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .far_data(far_data), .near_data(near_data), .adapt_en(adapt_en), .bypass(bypass),
        .coef_clr(coef_clr), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_rdata(coef_rdata), .out_valid(out_valid), .out_data(out_data), .est_data(est_data)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w-1)) - 1;
        lo = -(longint'(1) <<< (w-1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            hm[k] = 0;
            xm[k] = 0;
        end
    endtask

    // One frame of the echo canceller in plain arithmetic.
    task automatic model_frame(input int far, input int near, input bit adapt, input bit byp,
                               output longint y, output longint e);
        longint acc;
        for (int k = TAPS-1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = far;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += hm[k] * xm[k];
        y = byp ? 0 : sat(acc >>> (CW-1), DW);
        e = sat(longint'(near) - y, DW);
        if (adapt && !byp)
            for (int k = 0; k < TAPS; k++)
                hm[k] = sat(hm[k] + ((e * xm[k] + (longint'(1) <<< (DW-2+MU_SHIFT))) >>> (DW-1+MU_SHIFT)), CW);
    endtask

    task automatic run_frame(input int far, input int near, input bit adapt, input bit byp, input string tag);
        longint ey, ee;
        int wt, lat, thr, ov;
        model_frame(far, near, adapt, byp, ey, ee);
        far_data = far[DW-1:0]; near_data = near[DW-1:0];
        adapt_en = adapt; bypass = byp; in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 200) begin @(posedge clk); #1; wt++; end
        check({tag, "_rdy"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, byp ? 1 : TAPS+1);
        check({tag, "_est"}, longint'($signed(est_data)), ey);
        check({tag, "_out"}, longint'($signed(out_data)), ee);
        thr = lat; ov = 1;
        while (!in_ready && thr < 400) begin
            @(posedge clk); #1; thr++;
            if (out_valid) ov++;
        end
        @(posedge clk); #1;
        if (out_valid) ov++;
        check({tag, "_thr"}, thr, (adapt && !byp) ? 2*TAPS+1 : lat);
        check({tag, "_pulse"}, ov, 1);
    endtask

    task automatic read_coef(input int a, output longint v);
        coef_addr = a[AW-1:0];
        @(posedge clk); #1;
        v = longint'($signed(coef_rdata));
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we = 1'b1; coef_addr = a[AW-1:0]; coef_wdata = v[CW-1:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (a < TAPS) hm[a] = sat(v, CW);
    endtask

    task automatic pulse_clr();
        coef_clr = 1'b1;
        @(posedge clk); #1;
        coef_clr = 1'b0;
        model_clear();
    endtask

    task automatic check_all_coefs(input string tag);
        longint v;
        for (int k = 0; k < TAPS; k++) begin
            read_coef(k, v);
            check($sformatf("%s_h%0d", tag, k), v, hm[k]);
        end
        read_coef(TAPS + 5, v);
        check({tag, "_hoor"}, v, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint v;
        int wt, cnt, f, n;
        rst = 1'b1; in_valid = 1'b0; adapt_en = 1'b0; bypass = 1'b0; coef_clr = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_wdata = '0; far_data = '0; near_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'($signed(out_data)), 0);
        check("rst_est_data", longint'($signed(est_data)), 0);
        check("rst_rdata", longint'($signed(coef_rdata)), 0);
        check_all_coefs("rst");

        run_frame(1000, 500, 1'b0, 1'b0, "idle");
        check("idle_out_lit", longint'($signed(out_data)), 500);

        write_coef(0, 16384);
        run_frame(8192, 0, 1'b0, 1'b0, "load0");
        check("load0_est_lit", longint'($signed(est_data)), 4096);
        check("load0_out_lit", longint'($signed(out_data)), -4096);
        write_coef(1, 16384);
        run_frame(0, 0, 1'b0, 1'b0, "load1");
        check("load1_est_lit", longint'($signed(est_data)), 4096);

        pulse_clr();
        write_coef(0, 32767);
        run_frame(32767, -32768, 1'b0, 1'b0, "sat");
        check("sat_est_lit", longint'($signed(est_data)), 32766);
        check("sat_out_lit", longint'($signed(out_data)), -32768);
        pulse_clr();
        for (int i = 0; i < 4; i++) run_frame(32767, 32767, 1'b1, 1'b0, "satad");
        read_coef(0, v);
        check("satad_h0_lit", v, 32767);
        check_all_coefs("satad");

        pulse_clr();
        run_frame(16384, 16384, 1'b1, 1'b0, "step");
        check("step_out_lit", longint'($signed(out_data)), 16384);
        read_coef(0, v);
        check("step_h0_lit", v, 8192);
        check_all_coefs("step");

        run_frame(-12345, 4321, 1'b1, 1'b1, "byp");
        check("byp_out_lit", longint'($signed(out_data)), 4321);
        check_all_coefs("byp");

        // Busy-time write is dropped, then a clear lands mid-update.
        write_coef(0, 12000);
        write_coef(1, -7000);
        begin
            longint ey, ee;
            model_frame(20000, -15000, 1'b0, 1'b0, ey, ee);
            far_data = 16'sd20000; near_data = -16'sd15000; adapt_en = 1'b1; bypass = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            coef_we = 1'b1; coef_addr = 4'd1; coef_wdata = 16'd1234;
            @(posedge clk); #1;
            coef_we = 1'b0;
            @(posedge clk); #1;
            check("we_busy_rdata", longint'($signed(coef_rdata)), -7000);
            wt = 0;
            while (!out_valid && wt < 200) begin @(posedge clk); #1; wt++; end
            check("clr_frame_out", longint'($signed(out_data)), ee);
            @(posedge clk); #1;
            pulse_clr();
            wt = 0;
            while (!in_ready && wt < 200) begin @(posedge clk); #1; wt++; end
            check("clr_ready", longint'(in_ready), 1);
            check_all_coefs("clr");
        end

        write_coef(2, 9000);
        far_data = 16'sd3000; near_data = 16'sd100; adapt_en = 1'b1; bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        check("abort_ready", longint'(in_ready), 1);
        cnt = 0;
        for (int i = 0; i < TAPS + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("abort_no_valid", cnt, 0);
        check_all_coefs("abort");

        for (int i = 0; i < 60; i++) begin
            if (i % 20 == 19) pulse_clr();
            if (i % 7 == 3) write_coef($urandom_range(0, TAPS + 1), int'($urandom_range(0, 65535)) - 32768);
            f = int'($urandom_range(0, 65535)) - 32768;
            n = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 2) == 0) begin f = f / 16; n = n / 16; end
            run_frame(f, n, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), $sformatf("rnd%0d", i));
            if (i % 6 == 5) begin
                int a;
                a = $urandom_range(0, TAPS - 1);
                read_coef(a, v);
                check($sformatf("rnd%0d_h%0d", i, a), v, hm[a]);
            end
        end
        check_all_coefs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
